// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM state, grant memory and default latency.
package mem_arb_pkg;

   localparam int MEM_LAT_DEFAULT = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_I = 2'd1,
      WAIT_D = 2'd2
   } arb_state_e;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and single-port memory command bundle seen by the arbiter.
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int AW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_flush;
   logic [31:0]   if_rdata;
   logic          if_valid;
   logic          if_stall;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wdata;
   logic [3:0]    d_be;
   logic [31:0]   d_rdata;
   logic          d_valid;
   logic          d_stall;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;
   logic [31:0]   mem_rdata;

   arb_state_e    arb_state;

   // Requests are levels held until the matching valid pulse; valid lasts one
   // cycle and a port is not re-granted in its own valid cycle.
   modport slave (
      input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
      output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
      output mem_en, mem_we, mem_addr, mem_wdata, mem_be, arb_state
   );

   modport master (
      output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
      input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
      input  mem_en, mem_we, mem_addr, mem_wdata, mem_be, arb_state
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one fixed-latency memory port, one transaction in flight.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT = MEM_LAT_DEFAULT,
   parameter int AW      = 32
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);

   localparam int            CW       = $clog2(MEM_LAT + 1);
   localparam logic [CW-1:0] LAT_LOAD = CW'(MEM_LAT);

   arb_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   grant_e        last_q, last_d;
   logic          flush_q, flush_d;
   logic          if_valid_q, if_valid_d;
   logic          d_valid_q, d_valid_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic [31:0]   d_rdata_q, d_rdata_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    be_q, be_d;

   logic          if_elig, d_elig, grant_i, issue, flushed;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;

   always_comb begin
      if_elig    = bus.if_req & ~if_valid_q;
      d_elig     = bus.d_req & ~d_valid_q;
      grant_i    = if_elig & (~d_elig | (last_q == GRANT_D));
      issue      = ~rst & (state_q == IDLE) & (if_elig | d_elig);
      flushed    = flush_q | bus.if_flush;
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      flush_d    = flush_q;
      if_valid_d = 1'b0;
      d_valid_d  = 1'b0;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = addr_q;
      mem_wdata  = wdata_q;
      mem_be     = be_q;

      unique case (state_q)
         IDLE: begin
            if (issue) begin
               mem_en  = 1'b1;
               flush_d = 1'b0;
               cnt_d   = LAT_LOAD;
               if (grant_i) begin
                  mem_addr = bus.if_addr;
                  mem_be   = 4'hF;
                  last_d   = GRANT_I;
                  state_d  = WAIT_I;
               end else begin
                  mem_we    = bus.d_we;
                  mem_addr  = bus.d_addr;
                  mem_wdata = bus.d_wdata;
                  mem_be    = bus.d_be;
                  last_d    = GRANT_D;
                  // Writes need no response slot: acknowledge next cycle from IDLE.
                  if (bus.d_we) begin
                     d_valid_d = 1'b1;
                     cnt_d     = '0;
                  end else begin
                     state_d = WAIT_D;
                  end
               end
            end
         end
         WAIT_I, WAIT_D: begin
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            if (state_q == WAIT_I) flush_d = flushed;
            if (cnt_q <= CW'(1)) begin
               state_d = IDLE;
               if (state_q == WAIT_D) begin
                  d_valid_d = 1'b1;
                  d_rdata_d = bus.mem_rdata;
               end else if (!flushed) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = bus.mem_rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      be_d    = mem_be;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         last_q     <= GRANT_I;
         flush_q    <= 1'b0;
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         flush_q    <= flush_d;
         if_valid_q <= if_valid_d;
         d_valid_q  <= d_valid_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
      end
   end

   // Valids are masked while reset is held so stalls track the raw requests.
   assign bus.if_valid  = if_valid_q & ~rst;
   assign bus.d_valid   = d_valid_q & ~rst;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.if_stall  = bus.if_req & ~(if_valid_q & ~rst);
   assign bus.d_stall   = bus.d_req & ~(d_valid_q & ~rst);
   assign bus.mem_en    = mem_en;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = mem_addr;
   assign bus.mem_wdata = mem_wdata;
   assign bus.mem_be    = mem_be;
   assign bus.arb_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2 and a fixed-latency memory model.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW      = 32;
   localparam int MEM_LAT = 2;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   mem_port_arbiter_if #(.AW(AW)) bus ();

   mem_port_arbiter #(.MEM_LAT(MEM_LAT), .AW(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: read data for the address presented MEM_LAT cycles earlier.
   logic [AW-1:0] pipe_addr [MEM_LAT];
   always @(posedge clk) begin
      pipe_addr[0] <= bus.mem_addr;
      for (int k = 1; k < MEM_LAT; k++) pipe_addr[k] <= pipe_addr[k-1];
   end

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      case (a)
         32'h0040_0000: return 32'h2008_0005;
         32'h0040_0020: return 32'h8FBF_0010;
         32'h1001_0000: return 32'hD0DF_0000;
         default:       return 32'h0BAD_0BAD;
      endcase
   endfunction

   assign bus.mem_rdata = mem_word(pipe_addr[MEM_LAT-1]);

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic chk_out(input string tag, input logic en, input logic iv, input logic dv);
      check_eq({tag, "_mem_en"}, bus.mem_en, en);
      check_eq({tag, "_if_valid"}, bus.if_valid, iv);
      check_eq({tag, "_d_valid"}, bus.d_valid, dv);
   endtask

   task automatic clear_inputs();
      bus.if_req   = 1'b0;
      bus.if_addr  = '0;
      bus.if_flush = 1'b0;
      bus.d_req    = 1'b0;
      bus.d_we     = 1'b0;
      bus.d_addr   = '0;
      bus.d_wdata  = '0;
      bus.d_be     = 4'hF;
   endtask

   // Holds reset two cycles with a fetch request pending, then releases it;
   // the caller's next assignments form cycle 0.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      clear_inputs();
      bus.if_req = 1'b1;
      cyc();
      cyc();
      sample();
      check_eq({tag, "_rst_state"}, bus.arb_state, IDLE);
      check_eq({tag, "_rst_if_stall"}, bus.if_stall, 1'b1);
      check_eq({tag, "_rst_d_stall"}, bus.d_stall, 1'b0);
      check_eq({tag, "_rst_if_rdata"}, bus.if_rdata, 32'h0);
      check_eq({tag, "_rst_d_rdata"}, bus.d_rdata, 32'h0);
      chk_out({tag, "_rst"}, 1'b0, 1'b0, 1'b0);
      check_eq({tag, "_rst_mem_we"}, bus.mem_we, 1'b0);
      cyc();
      rst = 1'b0;
      clear_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      clear_inputs();

      // Fetch only, with a flush asserted in the issue cycle (ignored in IDLE).
      do_reset("t1");
      bus.if_req = 1'b1; bus.if_addr = 32'h0040_0000; bus.if_flush = 1'b1;
      sample();
      chk_out("t1_c0", 1'b1, 1'b0, 1'b0);
      check_eq("t1_c0_addr", bus.mem_addr, 32'h0040_0000);
      check_eq("t1_c0_we", bus.mem_we, 1'b0);
      check_eq("t1_c0_be", bus.mem_be, 4'hF);
      check_eq("t1_c0_stall", bus.if_stall, 1'b1);
      cyc(); bus.if_flush = 1'b0; sample();
      chk_out("t1_c1", 1'b0, 1'b0, 1'b0);
      check_eq("t1_c1_state", bus.arb_state, WAIT_I);
      cyc(); sample();
      chk_out("t1_c2", 1'b0, 1'b0, 1'b0);
      check_eq("t1_c2_stall", bus.if_stall, 1'b1);
      cyc(); sample();
      chk_out("t1_c3", 1'b0, 1'b1, 1'b0);
      check_eq("t1_c3_rdata", bus.if_rdata, 32'h2008_0005);
      check_eq("t1_c3_stall", bus.if_stall, 1'b0);
      cyc(); bus.if_req = 1'b0; sample();
      chk_out("t1_c4", 1'b0, 1'b0, 1'b0);
      check_eq("t1_c4_rdata_hold", bus.if_rdata, 32'h2008_0005);

      // Simultaneous fetch and data read; flush during WAIT_D is ignored.
      do_reset("t2");
      bus.if_req = 1'b1; bus.if_addr = 32'h0040_0000;
      bus.d_req = 1'b1; bus.d_addr = 32'h1001_0000; bus.d_be = 4'hF;
      sample();
      chk_out("t2_c0", 1'b1, 1'b0, 1'b0);
      check_eq("t2_c0_addr", bus.mem_addr, 32'h1001_0000);
      cyc(); bus.if_flush = 1'b1; sample();
      chk_out("t2_c1", 1'b0, 1'b0, 1'b0);
      check_eq("t2_c1_state", bus.arb_state, WAIT_D);
      cyc(); bus.if_flush = 1'b0; sample();
      chk_out("t2_c2", 1'b0, 1'b0, 1'b0);
      cyc(); sample();
      chk_out("t2_c3", 1'b1, 1'b0, 1'b1);
      check_eq("t2_c3_d_rdata", bus.d_rdata, 32'hD0DF_0000);
      check_eq("t2_c3_addr", bus.mem_addr, 32'h0040_0000);
      check_eq("t2_c3_be", bus.mem_be, 4'hF);
      cyc(); bus.d_req = 1'b0; sample();
      chk_out("t2_c4", 1'b0, 1'b0, 1'b0);
      cyc(); sample();
      chk_out("t2_c5", 1'b0, 1'b0, 1'b0);
      cyc(); sample();
      chk_out("t2_c6", 1'b0, 1'b1, 1'b0);
      check_eq("t2_c6_if_rdata", bus.if_rdata, 32'h2008_0005);
      cyc(); bus.if_req = 1'b0;

      // Data write with fetch pending: write acked next cycle, fetch issued then.
      do_reset("t3");
      bus.if_req = 1'b1; bus.if_addr = 32'h0040_0000;
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1001_0004;
      bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'b0011;
      sample();
      chk_out("t3_c0", 1'b1, 1'b0, 1'b0);
      check_eq("t3_c0_we", bus.mem_we, 1'b1);
      check_eq("t3_c0_be", bus.mem_be, 4'b0011);
      check_eq("t3_c0_addr", bus.mem_addr, 32'h1001_0004);
      check_eq("t3_c0_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      cyc(); sample();
      chk_out("t3_c1", 1'b1, 1'b0, 1'b1);
      check_eq("t3_c1_d_rdata", bus.d_rdata, 32'h0);
      check_eq("t3_c1_we", bus.mem_we, 1'b0);
      check_eq("t3_c1_addr", bus.mem_addr, 32'h0040_0000);
      check_eq("t3_c1_be", bus.mem_be, 4'hF);
      cyc(); bus.d_req = 1'b0; bus.d_we = 1'b0; sample();
      chk_out("t3_c2", 1'b0, 1'b0, 1'b0);
      check_eq("t3_c2_we", bus.mem_we, 1'b0);
      check_eq("t3_c2_addr_hold", bus.mem_addr, 32'h0040_0000);
      check_eq("t3_c2_wdata_hold", bus.mem_wdata, 32'hDEAD_BEEF);
      cyc(); sample();
      chk_out("t3_c3", 1'b0, 1'b0, 1'b0);
      cyc(); sample();
      chk_out("t3_c4", 1'b0, 1'b1, 1'b0);
      check_eq("t3_c4_if_rdata", bus.if_rdata, 32'h2008_0005);
      cyc(); bus.if_req = 1'b0;

      // Continuous requests on both ports: grants alternate D,I,D,I.
      do_reset("t4");
      bus.if_req = 1'b1; bus.if_addr = 32'h0040_0000;
      bus.d_req = 1'b1; bus.d_addr = 32'h1001_0000;
      for (int c = 0; c < 12; c++) begin
         if (c != 0) cyc();
         sample();
         chk_out($sformatf("t4_c%0d", c), (c % 3) == 0, c == 6, (c == 3) || (c == 9));
         if ((c % 3) == 0)
            check_eq($sformatf("t4_c%0d_addr", c), bus.mem_addr,
                     ((c / 3) % 2 == 0) ? 64'h1001_0000 : 64'h0040_0000);
      end
      cyc(); bus.if_req = 1'b0; bus.d_req = 1'b0;

      // Flush during WAIT_I drops that response; redirected fetch follows.
      do_reset("t5");
      bus.if_req = 1'b1; bus.if_addr = 32'h0040_0000;
      sample();
      chk_out("t5_c0", 1'b1, 1'b0, 1'b0);
      cyc(); bus.if_flush = 1'b1; bus.if_addr = 32'h0040_0020; sample();
      chk_out("t5_c1", 1'b0, 1'b0, 1'b0);
      cyc(); bus.if_flush = 1'b0; sample();
      chk_out("t5_c2", 1'b0, 1'b0, 1'b0);
      cyc(); sample();
      chk_out("t5_c3", 1'b1, 1'b0, 1'b0);
      check_eq("t5_c3_addr", bus.mem_addr, 32'h0040_0020);
      check_eq("t5_c3_if_rdata", bus.if_rdata, 32'h0);
      cyc(); sample();
      chk_out("t5_c4", 1'b0, 1'b0, 1'b0);
      cyc(); sample();
      chk_out("t5_c5", 1'b0, 1'b0, 1'b0);
      cyc(); sample();
      chk_out("t5_c6", 1'b0, 1'b1, 1'b0);
      check_eq("t5_c6_if_rdata", bus.if_rdata, 32'h8FBF_0010);
      cyc(); bus.if_req = 1'b0;

      // Reset in the middle of a data read abandons it; reissue on release.
      do_reset("t6");
      bus.d_req = 1'b1; bus.d_addr = 32'h1001_0000;
      sample();
      chk_out("t6_c0", 1'b1, 1'b0, 1'b0);
      cyc(); rst = 1'b1; sample();
      chk_out("t6_c1", 1'b0, 1'b0, 1'b0);
      check_eq("t6_c1_d_stall", bus.d_stall, 1'b1);
      cyc(); rst = 1'b0; sample();
      chk_out("t6_c2", 1'b1, 1'b0, 1'b0);
      check_eq("t6_c2_addr", bus.mem_addr, 32'h1001_0000);
      cyc(); sample();
      chk_out("t6_c3", 1'b0, 1'b0, 1'b0);
      cyc(); sample();
      chk_out("t6_c4", 1'b0, 1'b0, 1'b0);
      cyc(); sample();
      chk_out("t6_c5", 1'b0, 1'b0, 1'b1);
      check_eq("t6_c5_d_rdata", bus.d_rdata, 32'hD0DF_0000);
      cyc(); bus.d_req = 1'b0;

      // Request dropped before its response still completes normally.
      do_reset("t7");
      bus.d_req = 1'b1; bus.d_addr = 32'h1001_0000;
      sample();
      chk_out("t7_c0", 1'b1, 1'b0, 1'b0);
      cyc(); bus.d_req = 1'b0; sample();
      check_eq("t7_c1_d_stall", bus.d_stall, 1'b0);
      check_eq("t7_c1_state", bus.arb_state, WAIT_D);
      cyc(); sample();
      chk_out("t7_c2", 1'b0, 1'b0, 1'b0);
      cyc(); sample();
      chk_out("t7_c3", 1'b0, 1'b0, 1'b1);
      check_eq("t7_c3_d_rdata", bus.d_rdata, 32'hD0DF_0000);
      check_eq("t7_c3_state", bus.arb_state, IDLE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning cycles from mem_en to valid mem_rdata; legal range 1..7.
REQ-002 SHALL have parameter AW, default 32, meaning byte-address width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 if_req  input  1  fetch request, level, held until if_valid.
REQ-006 if_addr  input  AW  fetch byte address.
REQ-007 if_flush  input  1  branch/jump taken; in-flight fetch discarded.
REQ-008 if_rdata  output  32  fetched instruction.
REQ-009 if_valid  output  1  one-cycle pulse, if_rdata valid.
REQ-010 if_stall  output  1  if_req and not if_valid.
REQ-011 d_req, d_we  input  1 each  data request (level, held until d_valid) and write select.
REQ-012 d_addr  input  AW;  d_wdata  input  32;  d_be  input  4  data address, write data, byte enables.
REQ-013 d_rdata  output  32;  d_valid  output  1;  d_stall  output  1  as fetch equivalents.
REQ-014 mem_en, mem_we  output  1 each;  mem_addr  output  AW;  mem_wdata  output  32;  mem_be  output  4  single-port memory command.
REQ-015 mem_rdata  input  32  memory read data, valid MEM_LAT cycles after mem_en.

Function
REQ-016 SHALL use FSM states IDLE, WAIT_I, WAIT_D; at most one transaction outstanding.
REQ-017 In IDLE with an eligible request, SHALL issue it: mem_en=1 for exactly one cycle, address/data/be/we from the granted port, then enter WAIT_I or WAIT_D.
REQ-018 Both eligible: SHALL grant data port, unless the previous completed grant was data and if_req is pending, then grant fetch (no starvation).
REQ-019 Fetch issues SHALL drive mem_we=0 and mem_be=4'hF.
REQ-020 Read issued in cycle T: SHALL register mem_rdata at end of cycle T+MEM_LAT and pulse the port's valid in cycle T+MEM_LAT+1 with rdata stable that cycle.
REQ-021 Write issued in cycle T: SHALL pulse d_valid in cycle T+1; d_rdata unchanged.
REQ-022 SHALL return to IDLE in the valid cycle; new issue allowed that same cycle (read throughput one per MEM_LAT+1 cycles).
REQ-023 A port SHALL NOT be eligible in the cycle its own valid is asserted; the other port may issue then.
REQ-024 if_flush during WAIT_I SHALL suppress that if_valid pulse; FSM still waits for the response slot before returning to IDLE; if_rdata not updated.
REQ-025 if_flush in IDLE or WAIT_D SHALL have no effect; if_flush with if_req in IDLE SHALL still issue the fetch.
REQ-026 Latency counter SHALL be clog2(MEM_LAT+1) bits, load MEM_LAT on issue, decrement to 0, no wrap.
REQ-027 When no issue occurs, mem_en=0 and mem_we=0; other mem_* outputs hold last value.
REQ-028 Request dropped before its valid (protocol violation) SHALL not corrupt FSM; response completes and valid still pulses.

Reset
REQ-029 rst SHALL force IDLE, counter=0, priority memory = fetch-last, all valid/mem_en/mem_we=0, rdata registers=0.
REQ-030 rst mid-transaction SHALL abandon it with no valid pulse; first post-reset issue in first cycle with rst=0.
REQ-031 if_stall/d_stall SHALL equal req during reset (no valid).

Structure
REQ-032 Package mem_arb_pkg SHALL hold FSM state enum (IDLE, WAIT_I, WAIT_D) and default MEM_LAT constant.
REQ-033 SHALL be a single module; no sub-module needed.

Verification (MEM_LAT=2)
REQ-034 Fetch only: if_req, if_addr=0x00400000 at cycle 0, mem_rdata=0x20080005 at cycle 2 -> mem_en cycle 0, if_valid+if_rdata=0x20080005 cycle 3, if_stall cycles 0-2.
REQ-035 Simultaneous if_req and d_req read 0x10010000 at cycle 0 -> data issued cycle 0, d_valid cycle 3; fetch issued cycle 3, if_valid cycle 6.
REQ-036 Data write d_addr=0x10010004, d_wdata=0xDEADBEEF, d_be=4'b0011 with if_req -> mem_we=1, mem_be=0011 cycle 0, d_valid cycle 1, fetch issued cycle 1.
REQ-037 Continuous d_req and if_req for 12 cycles -> issues alternate D,I,D,I; no port waits more than 2 slots.
REQ-038 if_flush at cycle 1 during fetch issued cycle 0 -> no if_valid cycle 3; new if_addr=0x00400020 issued cycle 3, if_valid cycle 6.
REQ-039 rst asserted cycle 1 of data read -> no d_valid; after release, pending d_req issued immediately, d_valid 3 cycles later.
